// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and sizing helper for the traffic controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10
   } light_t;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2
   } phase_t;

   function automatic int max3(input int a, input int b, input int c);
      int mx;
      mx = (a > b) ? a : b;
      return (mx > c) ? mx : c;
   endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin search: first requesting index after cur (wrapping), cur excluded.
module rr_next_dir #(
   parameter int N_DIR = 4,
   parameter int W     = 2
) (
   input  logic [N_DIR-1:0] req,
   input  logic [W-1:0]     cur,
   output logic [W-1:0]     nxt,
   output logic             vld
);

   logic [W-1:0] idx;

   always_comb begin
      nxt = '0;
      vld = 1'b0;
      idx = '0;
      for (int k = 1; k < N_DIR; k++) begin
         idx = W'((int'(cur) + k) % N_DIR);
         if (!vld && req[idx]) begin
            vld = 1'b1;
            nxt = idx;
         end
      end
   end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-direction traffic-light controller: round-robin green/yellow/all-red cycle
// with min/max green limits and a latched hold mode pinning HOLD_DIR.
module traffic_ctrl_n
   import traffic_pkg::*;
#(
   parameter int N_DIR      = 4,
   parameter int GREEN_MIN  = 5,
   parameter int GREEN_MAX  = 20,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 1,
   parameter int HOLD_DIR   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       p,
   input  logic                       r,
   input  logic [N_DIR-1:0]           traffic,
   output logic [2*N_DIR-1:0]         lights,
   output logic [$clog2(N_DIR)-1:0]   active_dir,
   output logic                       m
);

   localparam int W    = $clog2(N_DIR);
   localparam int TMAX = max3(GREEN_MAX, YELLOW_CYC, ALLRED_CYC);
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] G_MIN1 = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] G_MAX1 = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] Y_END  = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] A_END  = TW'(ALLRED_CYC - 1);
   // Saturate at the longest phase so a long yellow/all-red can still time out.
   localparam logic [TW-1:0] T_SAT  = TW'(TMAX);
   localparam logic [W-1:0]  HOLD_W = W'(HOLD_DIR);

   phase_t          phase, phase_n;
   logic [W-1:0]    dir, dir_n, nxt, nxt_n, rr_dir;
   logic [TW-1:0]   timer, timer_n;
   logic            m_n, others, leave_green;

   rr_next_dir #(.N_DIR(N_DIR), .W(W)) u_rr (
      .req (traffic),
      .cur (dir),
      .nxt (rr_dir),
      .vld (others)
   );

   assign leave_green = !(m && dir == HOLD_W) && timer >= G_MIN1 && others &&
                        (!traffic[dir] || timer >= G_MAX1);

   always_comb begin
      phase_n = phase;
      dir_n   = dir;
      nxt_n   = nxt;
      unique case (phase)
         PH_GREEN: if (leave_green) begin
            phase_n = PH_YELLOW;
            nxt_n   = rr_dir;
         end
         PH_YELLOW: if (timer == Y_END) phase_n = PH_ALLRED;
         PH_ALLRED: if (timer == A_END) begin
            phase_n = PH_GREEN;
            dir_n   = nxt;
         end
         default: phase_n = PH_GREEN;
      endcase
      if (phase_n != phase)   timer_n = '0;
      else if (timer == T_SAT) timer_n = timer;
      else                     timer_n = timer + 1'b1;
      m_n = r ? 1'b0 : (p ? 1'b1 : m);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= PH_GREEN;
         dir   <= '0;
         nxt   <= '0;
         timer <= '0;
         m     <= 1'b0;
      end else begin
         phase <= phase_n;
         dir   <= dir_n;
         nxt   <= nxt_n;
         timer <= timer_n;
         m     <= m_n;
      end
   end

   always_comb begin
      lights = '0;
      for (int d = 0; d < N_DIR; d++) begin
         lights[2*d +: 2] = RED;
         if (W'(d) == dir) begin
            if (phase == PH_GREEN)       lights[2*d +: 2] = GREEN;
            else if (phase == PH_YELLOW) lights[2*d +: 2] = YELLOW;
         end
      end
   end

   assign active_dir = dir;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n at default parameters; expected lamp
// patterns are hand-derived cycle by cycle from the phase timing.
module tb_traffic_ctrl_n;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       p = 1'b0;
   logic       r = 1'b0;
   logic [3:0] traffic = 4'b0000;
   logic [7:0] lights;
   logic [1:0] active_dir;
   logic       m;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [1:0] LG = 2'b00, LY = 2'b01;

   traffic_ctrl_n dut (
      .clk        (clk),
      .reset      (reset),
      .p          (p),
      .r          (r),
      .traffic    (traffic),
      .lights     (lights),
      .active_dir (active_dir),
      .m          (m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected lamp vector: everything RED except direction d showing code c (d<0: all RED).
   function automatic logic [7:0] el(input int d, input logic [1:0] c);
      logic [7:0] v;
      v = 8'b10101010;
      if (d >= 0) v[2*d +: 2] = c;
      return v;
   endfunction

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
   task automatic do_reset(input logic [3:0] t);
      traffic = t;
      reset   = 1'b1;
      tick();
      reset   = 1'b0;
   endtask

   initial begin
      @(negedge clk);

      // 1: no demand, dir0 green forever
      do_reset(4'b0000);
      chk("rst_m", m, 1'b0);
      for (int k = 0; k < 50; k++) begin
         chk("idle_lights", lights, 8'b10101000);
         chk("idle_dir", active_dir, 2'd0);
         tick();
      end

      // 2: single demand on dir2, min green then switch
      do_reset(4'b0100);
      for (int k = 0; k <= 9; k++) begin
         if (k < 5)       chk("min_g", lights, el(0, LG));
         else if (k < 8)  chk("min_y", lights, el(0, LY));
         else if (k == 8) chk("min_ar", lights, el(-1, LG));
         else             chk("min_g2", lights, el(2, LG));
         tick();
      end
      chk("min_dir", active_dir, 2'd2);

      // 3: continuous demand on dir0 and dir1, max-green alternation
      do_reset(4'b0011);
      for (int k = 0; k <= 48; k++) begin
         if (k < 20)       chk("max_g0", lights, el(0, LG));
         else if (k < 23)  chk("max_y0", lights, el(0, LY));
         else if (k == 23) chk("max_ar0", lights, el(-1, LG));
         else if (k < 44)  chk("max_g1", lights, el(1, LG));
         else if (k < 47)  chk("max_y1", lights, el(1, LY));
         else if (k == 47) chk("max_ar1", lights, el(-1, LG));
         else              chk("max_back0", lights, el(0, LG));
         tick();
      end

      // 4: hold mode pins dir1 green
      do_reset(4'b1111);
      tick(24);
      chk("hold_dir1", active_dir, 2'd1);
      chk("hold_g1", lights, el(1, LG));
      p = 1'b1; tick(); p = 1'b0;
      chk("hold_m_set", m, 1'b1);
      for (int k = 0; k < 110; k++) begin
         chk("hold_pinned", lights, el(1, LG));
         tick();
      end
      r = 1'b1; tick(); r = 1'b0;
      chk("hold_m_clr", m, 1'b0);
      chk("hold_still_g", lights, el(1, LG));
      tick();
      chk("hold_rel_y", lights, el(1, LY));

      // 5: release wins over set; reset mid-yellow
      p = 1'b1; tick(); p = 1'b0;
      chk("pr_m_set", m, 1'b1);
      p = 1'b1; r = 1'b1; tick(); p = 1'b0; r = 1'b0;
      chk("pr_r_wins", m, 1'b0);
      chk("pr_still_y", lights, el(1, LY));
      p = 1'b1; reset = 1'b1; tick(); p = 1'b0; reset = 1'b0;
      chk("yrst_lights", lights, el(0, LG));
      chk("yrst_dir", active_dir, 2'd0);
      chk("yrst_m", m, 1'b0);
      tick(19);
      chk("yrst_t_g", lights, el(0, LG));
      tick();
      chk("yrst_t_y", lights, el(0, LY));

      // 6: next_dir latched at green exit
      do_reset(4'b0010);
      tick(9);
      chk("rr_dir1", active_dir, 2'd1);
      traffic = 4'b1001;
      tick(5);
      chk("rr_y1", lights, el(1, LY));
      traffic = 4'b0001;
      tick(3);
      chk("rr_ar", lights, el(-1, LG));
      chk("rr_dir_hold", active_dir, 2'd1);
      tick();
      chk("rr_g3", lights, el(3, LG));
      chk("rr_dir3", active_dir, 2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
